// File: rtl/output_mat_serializer.sv
// Drains a captured 8x8 matrix as sixteen 4-element words to a RAM write port
// using a valid/ready handshake, then pulses done for one cycle.
module output_mat_serializer #(
  parameter int DATA_WIDTH = 8,
  parameter int BANK_DEPTH = 8,
  parameter int ADDR_WIDTH = 6
) (
  input  logic                                                  clk,
  input  logic                                                  reset,
  input  logic                                                  start,
  input  logic                                                  abort,
  input  logic [ADDR_WIDTH-1:0]                                 base_addr,
  input  logic [BANK_DEPTH-1:0][BANK_DEPTH-1:0][DATA_WIDTH-1:0] mat_in,
  output logic [4*DATA_WIDTH-1:0]                               out_data,
  output logic [ADDR_WIDTH-1:0]                                 out_addr,
  output logic                                                  out_valid,
  input  logic                                                  out_ready,
  output logic                                                  busy,
  output logic                                                  done
);

  localparam int WORDS = BANK_DEPTH * BANK_DEPTH / 4;
  localparam int K_W   = $clog2(WORDS);
  localparam int RW    = $clog2(BANK_DEPTH);
  localparam logic [K_W-1:0] LAST_K = K_W'(WORDS - 1);

  typedef logic [BANK_DEPTH-1:0][BANK_DEPTH-1:0][DATA_WIDTH-1:0] mat_t;
  typedef enum logic [1:0] {IDLE, SEND, DONE} state_t;

  state_t                state;
  mat_t                  shadow;
  logic [ADDR_WIDTH-1:0] base_reg;
  logic [K_W-1:0]        k;
  logic [K_W-1:0]        k_next;

  assign k_next = k + K_W'(1);
  assign busy   = (state != IDLE);

  // Word idx covers row idx/2; its low bit picks the column half.
  // The lowest column lands in the most significant element slot.
  function automatic logic [4*DATA_WIDTH-1:0] pack_word(input mat_t m, input logic [K_W-1:0] idx);
    logic [4*DATA_WIDTH-1:0] w;
    logic [RW-1:0]           row;
    logic [RW-1:0]           col;
    w   = '0;
    row = idx[K_W-1:1];
    for (int j = 0; j < 4; j++) begin
      col = {idx[0], 2'(j)};
      w[(3-j)*DATA_WIDTH +: DATA_WIDTH] = m[row][col];
    end
    return w;
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      shadow    <= '0;
      base_reg  <= '0;
      k         <= '0;
      out_data  <= '0;
      out_addr  <= '0;
      out_valid <= 1'b0;
      done      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start && !abort) begin
            shadow    <= mat_in;
            base_reg  <= base_addr;
            k         <= '0;
            out_data  <= pack_word(mat_in, '0);
            out_addr  <= base_addr;
            out_valid <= 1'b1;
            state     <= SEND;
          end
        end
        SEND: begin
          // Abort outranks a transfer on the same edge.
          if (abort) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end else if (out_ready) begin
            if (k == LAST_K) begin
              out_valid <= 1'b0;
              done      <= 1'b1;
              state     <= DONE;
            end else begin
              k        <= k_next;
              out_data <= pack_word(shadow, k_next);
              out_addr <= base_reg + ADDR_WIDTH'(k_next);
            end
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          out_valid <= 1'b0;
          done      <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_output_mat_serializer.sv
// Directed bench for output_mat_serializer: each task drives one scenario and
// compares outputs on the falling edge against hand-derived expectations.
module tb_output_mat_serializer;
  localparam int DW = 8;
  localparam int BD = 8;
  localparam int AW = 6;

  logic                         clk = 1'b0;
  logic                         reset;
  logic                         start;
  logic                         abort;
  logic [AW-1:0]                base_addr;
  logic [BD-1:0][BD-1:0][DW-1:0] mat_in;
  logic [4*DW-1:0]              out_data;
  logic [AW-1:0]                out_addr;
  logic                         out_valid;
  logic                         out_ready;
  logic                         busy;
  logic                         done;

  int checks = 0;
  int failures = 0;

  output_mat_serializer #(.DATA_WIDTH(DW), .BANK_DEPTH(BD), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .base_addr(base_addr),
    .mat_in(mat_in), .out_data(out_data), .out_addr(out_addr), .out_valid(out_valid),
    .out_ready(out_ready), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // With mat_in[r][c] = 8r+c+off, word k holds elements 4k..4k+3 (plus off).
  function automatic logic [31:0] exp_word(input logic [7:0] b);
    return {b, b + 8'd1, b + 8'd2, b + 8'd3};
  endfunction

  task automatic set_pattern(input logic [7:0] off);
    for (int r = 0; r < BD; r++)
      for (int c = 0; c < BD; c++)
        mat_in[r][c] = 8'(8 * r + c) + off;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic test_reset();
    #3;
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || out_data !== 32'h0 || out_addr !== 6'h0) begin
      failures++;
      $display("FAIL reset_state: valid=%b busy=%b done=%b data=%h addr=%h, required all zero",
               out_valid, busy, done, out_data, out_addr);
    end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_release_idle: valid=%b busy=%b, required 0 0", out_valid, busy);
    end
  endtask

  task automatic test_basic();
    set_pattern(8'h00);
    base_addr = 6'h00;
    out_ready = 1'b1;
    pulse_start();
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || busy !== 1'b1 || done !== 1'b0) begin
        failures++;
        $display("FAIL basic_ctrl k=%0d: valid=%b busy=%b done=%b, required 1 1 0", k, out_valid, busy, done);
      end
      checks++;
      if (out_data !== exp_word(8'(4 * k)) || out_addr !== 6'(k)) begin
        failures++;
        $display("FAIL basic_word k=%0d: data=%h addr=%h, required data=%h addr=%h",
                 k, out_data, out_addr, exp_word(8'(4 * k)), 6'(k));
      end
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b1) begin
      failures++;
      $display("FAIL basic_done: done=%b valid=%b busy=%b, required 1 0 1", done, out_valid, busy);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL basic_after_done: done=%b busy=%b, required 0 0", done, busy);
    end
  endtask

  task automatic test_backpressure();
    int xfers;
    xfers = 0;
    set_pattern(8'h00);
    base_addr = 6'h00;
    out_ready = 1'b1;
    pulse_start();
    for (int k = 0; k < 16; k++) begin
      if (k == 5) begin
        repeat (3) begin
          @(negedge clk);
          out_ready = 1'b0;
          checks++;
          if (out_valid !== 1'b1 || out_data !== 32'h14151617 || out_addr !== 6'h05 || done !== 1'b0) begin
            failures++;
            $display("FAIL stall_hold: valid=%b data=%h addr=%h done=%b, required 1 14151617 05 0",
                     out_valid, out_data, out_addr, done);
          end
        end
      end
      @(negedge clk);
      out_ready = 1'b1;
      if (out_valid === 1'b1) xfers++;
      checks++;
      if (out_data !== exp_word(8'(4 * k)) || out_addr !== 6'(k)) begin
        failures++;
        $display("FAIL stall_word k=%0d: data=%h addr=%h, required data=%h addr=%h",
                 k, out_data, out_addr, exp_word(8'(4 * k)), 6'(k));
      end
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b1 || xfers != 16) begin
      failures++;
      $display("FAIL stall_done: done=%b transfers=%0d, required 1 and 16", done, xfers);
    end
    @(negedge clk);
  endtask

  task automatic test_wrap();
    logic [AW-1:0] ea;
    set_pattern(8'h00);
    base_addr = 6'h3A;
    out_ready = 1'b1;
    pulse_start();
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      ea = 6'h3A + 6'(k);
      checks++;
      if (out_data !== exp_word(8'(4 * k)) || out_addr !== ea || out_valid !== 1'b1) begin
        failures++;
        $display("FAIL wrap_word k=%0d: data=%h addr=%h valid=%b, required data=%h addr=%h valid=1",
                 k, out_data, out_addr, out_valid, exp_word(8'(4 * k)), ea);
      end
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b1) begin
      failures++;
      $display("FAIL wrap_done: done=%b, required 1", done);
    end
    @(negedge clk);
  endtask

  task automatic test_shadow();
    set_pattern(8'h00);
    base_addr = 6'h00;
    out_ready = 1'b1;
    pulse_start();
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      if (k == 3) begin
        set_pattern(8'h80);
        start = 1'b1;
      end
      if (k == 6) start = 1'b0;
      checks++;
      if (out_data !== exp_word(8'(4 * k)) || out_addr !== 6'(k)) begin
        failures++;
        $display("FAIL shadow_word k=%0d: data=%h addr=%h, required data=%h addr=%h",
                 k, out_data, out_addr, exp_word(8'(4 * k)), 6'(k));
      end
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b1) begin
      failures++;
      $display("FAIL shadow_done: done=%b, required 1", done);
    end
    @(negedge clk);
  endtask

  task automatic test_abort();
    bit bad;
    set_pattern(8'h00);
    base_addr = 6'h00;
    out_ready = 1'b1;
    pulse_start();
    for (int k = 0; k < 8; k++) @(negedge clk);
    checks++;
    if (out_data !== exp_word(8'd28) || out_addr !== 6'h07) begin
      failures++;
      $display("FAIL abort_at_word7: data=%h addr=%h, required 1c1d1e1f 07", out_data, out_addr);
    end
    abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("FAIL abort_idle: valid=%b busy=%b done=%b, required 0 0 0", out_valid, busy, done);
    end
    bad = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (done !== 1'b0 || out_valid !== 1'b0) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      failures++;
      $display("FAIL abort_quiet: saw done or valid after abort, required none");
    end
    base_addr = 6'h20;
    pulse_start();
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || out_data !== 32'h00010203 || out_addr !== 6'h20) begin
      failures++;
      $display("FAIL abort_restart: valid=%b data=%h addr=%h, required 1 00010203 20", out_valid, out_data, out_addr);
    end
    repeat (15) @(negedge clk);
    @(negedge clk);
    checks++;
    if (done !== 1'b1) begin
      failures++;
      $display("FAIL abort_restart_done: done=%b, required 1", done);
    end
    @(negedge clk);
  endtask

  task automatic test_abort_start_idle();
    set_pattern(8'h40);
    start = 1'b1;
    abort = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    abort = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL abort_start_idle: busy=%b valid=%b, required 0 0", busy, out_valid);
    end
  endtask

  task automatic test_back_to_back();
    set_pattern(8'h00);
    base_addr = 6'h00;
    out_ready = 1'b1;
    pulse_start();
    repeat (16) @(negedge clk);
    @(negedge clk);
    checks++;
    if (done !== 1'b1) begin
      failures++;
      $display("FAIL b2b_first_done: done=%b, required 1", done);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("FAIL b2b_idle: busy=%b done=%b, required 0 0", busy, done);
    end
    base_addr = 6'h10;
    pulse_start();
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || out_data !== 32'h00010203 || out_addr !== 6'h10) begin
      failures++;
      $display("FAIL b2b_restart: valid=%b data=%h addr=%h, required 1 00010203 10", out_valid, out_data, out_addr);
    end
    repeat (15) @(negedge clk);
    @(negedge clk);
    checks++;
    if (done !== 1'b1) begin
      failures++;
      $display("FAIL b2b_second_done: done=%b, required 1", done);
    end
    @(negedge clk);
  endtask

  task automatic test_async_reset();
    bit bad;
    set_pattern(8'h00);
    base_addr = 6'h00;
    out_ready = 1'b1;
    pulse_start();
    for (int k = 0; k < 10; k++) @(negedge clk);
    checks++;
    if (out_data !== 32'h24252627 || out_addr !== 6'h09) begin
      failures++;
      $display("FAIL areset_word9: data=%h addr=%h, required 24252627 09", out_data, out_addr);
    end
    #2 reset = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || out_data !== 32'h0 || out_addr !== 6'h0) begin
      failures++;
      $display("FAIL areset_immediate: valid=%b busy=%b done=%b data=%h addr=%h, required all zero",
               out_valid, busy, done, out_data, out_addr);
    end
    @(negedge clk);
    reset = 1'b1;
    bad = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (out_valid !== 1'b0 || done !== 1'b0 || busy !== 1'b0) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      failures++;
      $display("FAIL areset_quiet: output activity without start, required none");
    end
    pulse_start();
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || out_data !== 32'h00010203 || out_addr !== 6'h00) begin
      failures++;
      $display("FAIL areset_restart: valid=%b data=%h addr=%h, required 1 00010203 00", out_valid, out_data, out_addr);
    end
    repeat (15) @(negedge clk);
    @(negedge clk);
    checks++;
    if (done !== 1'b1) begin
      failures++;
      $display("FAIL areset_restart_done: done=%b, required 1", done);
    end
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    out_ready = 1'b0;
    base_addr = '0;
    set_pattern(8'h00);
    test_reset();
    test_basic();
    test_backpressure();
    test_wrap();
    test_shadow();
    test_abort();
    test_abort_start_idle();
    test_back_to_back();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/output_mat_serializer.md
OUTPUT_MAT_SERIALIZER -- requirements
Module: output_mat_serializer

Interface
REQ-001 Parameter DATA_WIDTH, default 8: width of one matrix element.
REQ-002 Parameter BANK_DEPTH, default 8: matrix is BANK_DEPTH x BANK_DEPTH; only 8 is supported.
REQ-003 Parameter ADDR_WIDTH, default 6: width of the RAM word address.
REQ-004 Port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-005 Port reset, input, 1: asynchronous, active-low reset; asserted while low.
REQ-006 Port start, input, 1: request to capture mat_in and begin draining it.
REQ-007 Port abort, input, 1: synchronous cancel of the current drain.
REQ-008 Port base_addr, input, ADDR_WIDTH: RAM address of the first output word.
REQ-009 Port mat_in, input, [BANK_DEPTH][BANK_DEPTH][DATA_WIDTH]: parallel matrix; mat_in[r][c] is row r, column c.
REQ-010 Port out_data, output, 4*DATA_WIDTH: one RAM write word of 4 elements.
REQ-011 Port out_addr, output, ADDR_WIDTH: RAM write address for out_data.
REQ-012 Port out_valid, output, 1: out_data and out_addr are valid.
REQ-013 Port out_ready, input, 1: the RAM side accepts the word.
REQ-014 Port busy, output, 1: high in every state except IDLE.
REQ-015 Port done, output, 1: single-cycle pulse after the last word is accepted.

Function
REQ-016 The FSM SHALL have exactly three states: IDLE, SEND and DONE.
REQ-017 In IDLE, start=1 SHALL capture all of mat_in into a shadow register, latch base_addr, clear word index k to 0 and go to SEND on the same edge.
REQ-018 start SHALL be ignored outside IDLE; the shadow register SHALL NOT change during SEND.
REQ-019 In SEND, out_valid SHALL be 1 and word k (0..15) SHALL map to row k/2; even k carries columns 0-3, odd k carries columns 4-7.
REQ-020 Packing SHALL place the lowest column of the word in out_data[4*DW-1 -: DW] and the highest column in out_data[DW-1:0].
REQ-021 out_addr SHALL equal (latched base_addr + k) modulo 2^ADDR_WIDTH; wrap-around is legal and SHALL NOT be flagged.
REQ-022 A word transfers on an edge where out_valid=1 and out_ready=1; k SHALL then increment.
REQ-023 While out_valid=1 and out_ready=0, out_data and out_addr SHALL be held stable.
REQ-024 When word 15 transfers, the FSM SHALL go to DONE; DONE SHALL assert done=1 and out_valid=0 for exactly one cycle, then return to IDLE.
REQ-025 First out_valid SHALL appear on the cycle after the start edge; with out_ready held high, 16 words SHALL go out in 16 consecutive cycles and done SHALL follow on cycle 17.
REQ-026 abort=1 in SEND or DONE SHALL return the FSM to IDLE on the next edge with out_valid=0 and no done pulse; abort SHALL take priority over a simultaneous transfer.
REQ-027 abort and start asserted together in IDLE: abort SHALL win and no capture SHALL occur.
REQ-028 A start in the cycle after done (back in IDLE) SHALL be accepted normally.

Reset
REQ-029 While reset=0: state=IDLE, k=0, out_valid=0, busy=0, done=0, out_data=0, out_addr=0, shadow register=0.
REQ-030 Reset asserted mid-SEND SHALL abandon the drain immediately, independent of clk; no done pulse SHALL follow.
REQ-031 After reset releases, the block SHALL need a new start before emitting anything.

Verification
REQ-032 mat_in[r][c]=8*r+c, base_addr=0, out_ready=1, start pulse -> words 0..15 at addresses 0..15; word 0=0x00010203, word 1=0x04050607, word 15=0x3C3D3E3F; done on cycle 17.
REQ-033 Same stimulus with out_ready low for 3 cycles at word 5 -> word 5 (0x14151617, addr 5) held for 4 cycles; total 16 transfers, no duplicates.
REQ-034 base_addr=0x3A -> addresses 0x3A..0x3F, then 0x00..0x09; data order unchanged.
REQ-035 mat_in changed and start re-pulsed during SEND -> output still equals the originally captured matrix.
REQ-036 abort at word 7 -> out_valid=0 and busy=0 next cycle, no done; a following start restarts from word 0.
REQ-037 reset driven low at word 9, between clock edges -> out_valid=0 and busy=0 immediately; no output until the next start.
